// File: rtl/module_captura_operandos_pkg.sv
// Keypad key codes, key-to-BCD decoding and operand capture states
// shared by the operand entry logic.
package pkg_teclado;

    localparam logic [3:0] K_1   = 4'd0;
    localparam logic [3:0] K_2   = 4'd1;
    localparam logic [3:0] K_3   = 4'd2;
    localparam logic [3:0] K_A   = 4'd3;
    localparam logic [3:0] K_4   = 4'd4;
    localparam logic [3:0] K_5   = 4'd5;
    localparam logic [3:0] K_6   = 4'd6;
    localparam logic [3:0] K_B   = 4'd7;
    localparam logic [3:0] K_7   = 4'd8;
    localparam logic [3:0] K_8   = 4'd9;
    localparam logic [3:0] K_9   = 4'd10;
    localparam logic [3:0] K_C   = 4'd11;
    localparam logic [3:0] K_AST = 4'd12;
    localparam logic [3:0] K_0   = 4'd13;
    localparam logic [3:0] K_NUM = 4'd14;
    localparam logic [3:0] K_D   = 4'd15;

    typedef enum logic [1:0] {
        CAPT_A = 2'd0,
        CAPT_B = 2'd1,
        LISTO  = 2'd2
    } estado_captura_t;

    typedef struct packed {
        logic       is_digit;
        logic [3:0] bcd;
    } tecla_t;

    // Map a scan code to its decimal value; non-digit keys return is_digit=0.
    function automatic tecla_t decodificar_tecla(input logic [3:0] code);
        tecla_t t;
        t.is_digit = 1'b1;
        t.bcd      = 4'd0;
        case (code)
            K_0:     t.bcd = 4'd0;
            K_1:     t.bcd = 4'd1;
            K_2:     t.bcd = 4'd2;
            K_3:     t.bcd = 4'd3;
            K_4:     t.bcd = 4'd4;
            K_5:     t.bcd = 4'd5;
            K_6:     t.bcd = 4'd6;
            K_7:     t.bcd = 4'd7;
            K_8:     t.bcd = 4'd8;
            K_9:     t.bcd = 4'd9;
            default: t.is_digit = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/module_detector_flanco.sv
// Rising-edge detector: pulso is high for the one cycle in which senal is
// high and was low on the previous edge.
module module_detector_flanco (
    input  logic clk,
    input  logic rst,
    input  logic senal,
    output logic pulso
);

    logic senal_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            senal_q <= 1'b0;
        end else begin
            senal_q <= senal;
        end
    end

    // Combinational so the event is acted on at the edge that first samples senal high.
    assign pulso = senal & ~senal_q;

endmodule

// File: rtl/module_captura_operandos.sv
// Builds two BCD operands from keypad events (digits, backspace, clear,
// confirm) and hands them to the arithmetic stage with a listo flag.
module module_captura_operandos
    import pkg_teclado::*;
#(
    parameter int unsigned DIGITOS = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   code,
    input  logic                         valido,
    output logic [4*DIGITOS-1:0]         op_a,
    output logic [4*DIGITOS-1:0]         op_b,
    output logic [4*DIGITOS-1:0]         display,
    output logic [$clog2(DIGITOS+1)-1:0] n_dig,
    output logic                         sel_op,
    output logic                         listo
);

    localparam int unsigned W  = 4 * DIGITOS;
    localparam int unsigned NW = $clog2(DIGITOS + 1);

    estado_captura_t state, state_d;
    logic [W-1:0]    cur, cur_d;
    logic [NW-1:0]   n_dig_d;
    logic [W-1:0]    op_a_d, op_b_d, display_d;
    logic            sel_op_d, listo_d;
    logic            evento;
    tecla_t          tecla;

    module_detector_flanco u_flanco (
        .clk   (clk),
        .rst   (rst),
        .senal (valido),
        .pulso (evento)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CAPT_A;
            cur     <= '0;
            n_dig   <= '0;
            op_a    <= '0;
            op_b    <= '0;
            display <= '0;
            sel_op  <= 1'b0;
            listo   <= 1'b0;
        end else begin
            state   <= state_d;
            cur     <= cur_d;
            n_dig   <= n_dig_d;
            op_a    <= op_a_d;
            op_b    <= op_b_d;
            display <= display_d;
            sel_op  <= sel_op_d;
            listo   <= listo_d;
        end
    end

    always_comb begin
        state_d = state;
        cur_d   = cur;
        n_dig_d = n_dig;
        op_a_d  = op_a;
        op_b_d  = op_b;
        tecla   = decodificar_tecla(code);

        if (evento) begin
            case (state)
                LISTO: begin
                    // A new digit starts a fresh calculation; other keys except C are ignored.
                    if (tecla.is_digit) begin
                        state_d = CAPT_A;
                        op_a_d  = '0;
                        op_b_d  = '0;
                        cur_d   = W'(tecla.bcd);
                        n_dig_d = (tecla.bcd != 4'd0) ? NW'(1) : '0;
                    end else if (code == K_C) begin
                        state_d = CAPT_A;
                        op_a_d  = '0;
                        op_b_d  = '0;
                        cur_d   = '0;
                        n_dig_d = '0;
                    end
                end
                default: begin
                    if (tecla.is_digit) begin
                        if (n_dig < NW'(DIGITOS)) begin
                            cur_d = W'({cur, tecla.bcd});
                            if (cur != '0 || tecla.bcd != 4'd0) begin
                                n_dig_d = n_dig + NW'(1);
                            end
                        end
                    end else if (code == K_AST) begin
                        if (n_dig != '0) begin
                            cur_d   = cur >> 4;
                            n_dig_d = n_dig - NW'(1);
                        end
                    end else if (code == K_C) begin
                        cur_d   = '0;
                        n_dig_d = '0;
                    end else if (code == K_A) begin
                        if (state == CAPT_A) begin
                            op_a_d  = cur;
                            state_d = CAPT_B;
                        end else begin
                            op_b_d  = cur;
                            state_d = LISTO;
                        end
                        cur_d   = '0;
                        n_dig_d = '0;
                    end
                end
            endcase
        end

        display_d = (state_d == LISTO) ? op_b_d : cur_d;
        sel_op_d  = (state_d != CAPT_A);
        listo_d   = (state_d == LISTO);
    end

endmodule
